// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM generator.
// Each channel holds a target width, clamped to safe limits when it is written,
// and an active width that is loaded only at frame boundaries. A frame in
// progress is therefore never shortened or stretched. The optional slew limit
// caps how far the active width can move toward its target in one frame.
module servo_pwm_multi #(
  parameter int NUM_CH    = 2,
  parameter int TICK_DIV  = 10,
  parameter int FRAME_US  = 20000,
  parameter int PW_W      = 12,
  parameter int MIN_PW    = 1000,
  parameter int MAX_PW    = 2000,
  parameter int CENTER_PW = 1500,
  parameter int SLEW_STEP = 0,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [PW_W-1:0]   wr_pw,
  output logic              wr_err,
  output logic              frame_start,
  output logic [NUM_CH-1:0] servo_out
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int CMP_W = (FC_W > PW_W) ? FC_W : PW_W;

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_US - 1);
  localparam logic [PW_W-1:0] MIN_V    = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0] MAX_V    = PW_W'(MAX_PW);
  localparam logic [PW_W-1:0] CENTER_V = PW_W'(CENTER_PW);
  localparam logic [PW_W-1:0] STEP_V   = PW_W'(SLEW_STEP);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic [PS_W-1:0] prescaler;
  logic [FC_W-1:0] frame_cnt;
  logic            en_frame;
  logic            tick;
  logic            boundary;
  logic            wr_valid;
  logic [PW_W-1:0] wr_clamped;
  logic [PW_W-1:0] target      [NUM_CH];
  logic [PW_W-1:0] active      [NUM_CH];
  logic [PW_W-1:0] next_active [NUM_CH];

  // Tick, frame boundary and write decode; the channel bound is checked one bit wider than wr_ch so NUM_CH itself is representable
  always_comb begin
    tick     = (prescaler == PS_LAST);
    boundary = tick && (frame_cnt == FC_LAST);
    wr_valid = ({1'b0, wr_ch} < NUM_CH_V);
    if (wr_pw < MIN_V) begin
      wr_clamped = MIN_V;
    end else if (wr_pw > MAX_V) begin
      wr_clamped = MAX_V;
    end else begin
      wr_clamped = wr_pw;
    end
  end

  // Width to load at the next boundary: the target itself, or a step of at most SLEW_STEP toward it
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      next_active[i] = target[i];
      if (SLEW_STEP != 0) begin
        if (target[i] > active[i]) begin
          if ((target[i] - active[i]) > STEP_V) begin
            next_active[i] = active[i] + STEP_V;
          end
        end else if ((active[i] - target[i]) > STEP_V) begin
          next_active[i] = active[i] - STEP_V;
        end
      end
    end
  end

  // Prescaler divides SYSCLK down to the tick rate; frame_cnt counts ticks within a frame
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      prescaler <= '0;
      frame_cnt <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
      if (boundary) begin
        frame_cnt <= '0;
      end else if (tick) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Frame boundary: latch enable and load active widths, so a frame never changes once it has started
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      frame_start <= 1'b0;
      en_frame    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= CENTER_V;
      end
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        en_frame <= enable;
        for (int i = 0; i < NUM_CH; i++) begin
          active[i] <= next_active[i];
        end
      end
    end
  end

  // Target writes land immediately; a write on the boundary cycle only reaches active at the following boundary
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      wr_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= CENTER_V;
      end
    end else begin
      wr_err <= wr_en && !wr_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && wr_valid && (wr_ch == CH_W'(i))) begin
          target[i] <= wr_clamped;
        end
      end
    end
  end

  // Registered PWM compare: channel i is high while the tick count is below its active width
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      servo_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        servo_out[i] <= en_frame && (CMP_W'(frame_cnt) < CMP_W'(active[i]));
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed, table-driven bench for servo_pwm_multi.
// Two instances share clock, reset and enable: "m" is the plain two-channel
// generator and "s" is a three-channel generator with slew limiting, which also
// has a channel index (3) that is out of range. Every table row is one frame,
// measured from one frame_start to the next (200 cycles with TICK_DIV=2,
// FRAME_US=100), counting the high cycles of each output.
module tb_servo_pwm_multi;

  typedef struct {
    int sel;
    int wrk;
    int ch;
    int pw;
    int enk;
    int enval;
    int m0;
    int m1;
    int s0;
    int s1;
    int err;
  } vec_t;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET;
  logic        enable;
  logic        wr_en_m;
  logic [0:0]  wr_ch_m;
  logic [11:0] wr_pw_m;
  logic        wr_err_m;
  logic        fs_m;
  logic [1:0]  so_m;
  logic        wr_en_s;
  logic [1:0]  wr_ch_s;
  logic [11:0] wr_pw_s;
  logic        wr_err_s;
  logic        fs_s;
  logic [2:0]  so_s;

  int errors = 0;
  int checks = 0;
  vec_t vec[20];

  servo_pwm_multi #(
    .NUM_CH(2), .TICK_DIV(2), .FRAME_US(100), .PW_W(12),
    .MIN_PW(10), .MAX_PW(80), .CENTER_PW(50), .SLEW_STEP(0)
  ) dut_m (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .enable(enable),
    .wr_en(wr_en_m), .wr_ch(wr_ch_m), .wr_pw(wr_pw_m),
    .wr_err(wr_err_m), .frame_start(fs_m), .servo_out(so_m)
  );

  servo_pwm_multi #(
    .NUM_CH(3), .TICK_DIV(2), .FRAME_US(100), .PW_W(12),
    .MIN_PW(10), .MAX_PW(80), .CENTER_PW(50), .SLEW_STEP(8)
  ) dut_s (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .enable(enable),
    .wr_en(wr_en_s), .wr_ch(wr_ch_s), .wr_pw(wr_pw_s),
    .wr_err(wr_err_s), .frame_start(fs_s), .servo_out(so_s)
  );

  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for the next negedge at which frame_start is high
  task automatic waitFrameStart(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge SYSCLK);
      cyc++;
      if (fs_m) break;
    end
  endtask

  // One frame starting at a frame_start negedge; optional write and enable change at given offsets
  task automatic applyStimulus(input vec_t v, output int m0, output int m1,
                               output int s0, output int s1, output int s2,
                               output int err, output int fs_bad);
    m0 = 0; m1 = 0; s0 = 0; s1 = 0; s2 = 0; err = 0; fs_bad = 0;
    for (int k = 0; k < 200; k++) begin
      if ((fs_m != (k == 0)) || (fs_s != (k == 0))) fs_bad++;
      m0 += int'(so_m[0]);
      m1 += int'(so_m[1]);
      s0 += int'(so_s[0]);
      s1 += int'(so_s[1]);
      s2 += int'(so_s[2]);
      err += (v.sel == 0) ? int'(wr_err_m) : int'(wr_err_s);
      wr_en_m = 1'b0;
      wr_en_s = 1'b0;
      if (k == v.wrk) begin
        if (v.sel == 0) begin
          wr_en_m = 1'b1;
          wr_ch_m = 1'(v.ch);
          wr_pw_m = 12'(v.pw);
        end else begin
          wr_en_s = 1'b1;
          wr_ch_s = 2'(v.ch);
          wr_pw_s = 12'(v.pw);
        end
      end
      if (k == v.enk) enable = v.enval[0];
      @(negedge SYSCLK);
    end
    wr_en_m = 1'b0;
    wr_en_s = 1'b0;
  endtask

  task automatic runRows(input int first, input int last);
    int m0, m1, s0, s1, s2, err, fs_bad;
    for (int r = first; r <= last; r++) begin
      applyStimulus(vec[r], m0, m1, s0, s1, s2, err, fs_bad);
      checkOutput($sformatf("row%0d_m_ch0_high", r), m0, vec[r].m0);
      checkOutput($sformatf("row%0d_m_ch1_high", r), m1, vec[r].m1);
      checkOutput($sformatf("row%0d_s_ch0_high", r), s0, vec[r].s0);
      checkOutput($sformatf("row%0d_s_ch1_high", r), s1, vec[r].s1);
      checkOutput($sformatf("row%0d_s_ch2_high", r), s2, vec[r].s1);
      checkOutput($sformatf("row%0d_wr_err", r), err, vec[r].err);
      checkOutput($sformatf("row%0d_frame_start", r), fs_bad, 0);
    end
  endtask

  initial begin
    int cyc;
    int m0, m1, s0, s1, s2, err, fs_bad;
    vec_t idle;

    // sel, wrk, ch, pw, enk, enval, m0, m1, s0, s1, err  (high times in cycles)
    vec[0]  = '{0, -1, 0,    0, -1, 0, 100, 100, 100, 100, 0};
    vec[1]  = '{0, 20, 0,   30, -1, 0, 100, 100, 100, 100, 0};
    vec[2]  = '{0, -1, 0,    0, -1, 0,  60, 100, 100, 100, 0};
    vec[3]  = '{0, 10, 1,    5, -1, 0,  60, 100, 100, 100, 0};
    vec[4]  = '{0, 30, 1, 4000, -1, 0,  60,  20, 100, 100, 0};
    vec[5]  = '{0,199, 0,   20, -1, 0,  60, 160, 100, 100, 0};
    vec[6]  = '{0, -1, 0,    0, -1, 0,  60, 160, 100, 100, 0};
    vec[7]  = '{0, -1, 0,    0, 20, 0,  40, 160, 100, 100, 0};
    vec[8]  = '{0, -1, 0,    0, 50, 1,   0,   0,   0,   0, 0};
    vec[9]  = '{0, -1, 0,    0, -1, 0,  40, 160, 100, 100, 0};
    vec[10] = '{0,  5, 0,   80, -1, 0,  40, 160, 100, 100, 0};
    vec[11] = '{0, -1, 0,    0, -1, 0, 160, 160, 100, 100, 0};
    vec[12] = '{1, 30, 0,   80, -1, 0, 100, 100, 100, 100, 0};
    vec[13] = '{1, 30, 3,   10, -1, 0, 100, 100, 116, 100, 1};
    vec[14] = '{1, -1, 0,    0, -1, 0, 100, 100, 132, 100, 0};
    vec[15] = '{1, -1, 0,    0, -1, 0, 100, 100, 148, 100, 0};
    vec[16] = '{1, -1, 0,    0, -1, 0, 100, 100, 160, 100, 0};
    vec[17] = '{1, 30, 0,   10, -1, 0, 100, 100, 160, 100, 0};
    vec[18] = '{1, -1, 0,    0, -1, 0, 100, 100, 144, 100, 0};
    vec[19] = '{1, -1, 0,    0, -1, 0, 100, 100, 128, 100, 0};
    idle    = '{0, -1, 0,    0, -1, 0,   0,   0,   0,   0, 0};

    SYSRESET = 1'b1;
    enable   = 1'b1;
    wr_en_m  = 1'b0; wr_ch_m = '0; wr_pw_m = '0;
    wr_en_s  = 1'b0; wr_ch_s = '0; wr_pw_s = '0;
    repeat (3) @(negedge SYSCLK);
    checkOutput("reset_servo_m", int'(so_m), 0);
    checkOutput("reset_servo_s", int'(so_s), 0);
    checkOutput("reset_frame_start", int'(fs_m), 0);
    checkOutput("reset_wr_err", int'(wr_err_m), 0);

    SYSRESET = 1'b0;
    waitFrameStart(cyc);
    checkOutput("first_frame_latency", cyc, 200);
    runRows(0, 11);

    $display("[TB] back-to-back writes to ch1, last one wins");
    wr_en_m = 1'b1; wr_ch_m = 1'b1; wr_pw_m = 12'd20;
    @(negedge SYSCLK);
    wr_pw_m = 12'd70;
    @(negedge SYSCLK);
    wr_en_m = 1'b0;
    waitFrameStart(cyc);
    checkOutput("multi_wr_wait", cyc, 198);
    applyStimulus(idle, m0, m1, s0, s1, s2, err, fs_bad);
    checkOutput("multi_wr_m_ch0_high", m0, 160);
    checkOutput("multi_wr_m_ch1_high", m1, 140);
    checkOutput("multi_wr_frame_start", fs_bad, 0);

    $display("[TB] reset in the middle of a pulse");
    repeat (10) @(negedge SYSCLK);
    checkOutput("pre_reset_servo_m", int'(so_m), 3);
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    checkOutput("mid_reset_servo_m", int'(so_m), 0);
    checkOutput("mid_reset_servo_s", int'(so_s), 0);
    repeat (2) @(negedge SYSCLK);
    SYSRESET = 1'b0;
    waitFrameStart(cyc);
    checkOutput("post_reset_latency", cyc, 200);

    $display("[TB] slew-limited channel and invalid channel write");
    runRows(12, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
